// File: rtl/audio_mix_pkg.sv
// Shared types and helpers for the click-free audio source selector:
// FSM state encoding, gain sizing and mute-request decoding.
package audio_mix_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FADE_OUT = 2'd1,
      FADE_IN  = 2'd2,
      MUTED    = 2'd3
   } mix_state_t;

   localparam int DEF_RAMP_LOG2 = 6;
   localparam int DEF_GAIN_W    = DEF_RAMP_LOG2 + 1;

   // Gain counts 0..2^ramp_log2 inclusive, so it needs one bit more than the ramp exponent.
   function automatic int gain_width(input int ramp_log2);
      return ramp_log2 + 1;
   endfunction

   function automatic int gain_full(input int ramp_log2);
      return 1 << ramp_log2;
   endfunction

   // Any select value outside the source range is treated as a mute request.
   function automatic logic req_is_mute(input logic mute, input int unsigned sel,
                                        input int unsigned n_src);
      return mute || (sel >= n_src);
   endfunction

endpackage

// File: rtl/gain_scaler.sv
// One channel of gain application: signed sample times unsigned gain,
// arithmetic shift right by RAMP_LOG2, truncated back to DATA_W.
module gain_scaler
   import audio_mix_pkg::*;
#(
   parameter int DATA_W    = 24,
   parameter int RAMP_LOG2 = 6
) (
   input  logic signed [DATA_W-1:0]      i_sample,
   input  logic [RAMP_LOG2:0]            i_gain,
   output logic [DATA_W-1:0]             o_scaled
);

   // |sample| * 2^RAMP_LOG2 always fits in DATA_W+RAMP_LOG2 signed bits, so the
   // modular product at this width is exact.
   localparam int PW = DATA_W + RAMP_LOG2;

   logic signed [PW-1:0] w_sample_x;
   logic signed [PW-1:0] w_gain_x;
   logic signed [PW-1:0] w_prod;

   assign w_sample_x = PW'(i_sample);
   assign w_gain_x   = PW'(i_gain);
   assign w_prod     = w_sample_x * w_gain_x;
   assign o_scaled   = DATA_W'(w_prod >>> RAMP_LOG2);

endmodule

// File: rtl/audio_mode_mux.sv
// Click-free output source selector: ramps gain to zero on a source change
// or mute, swaps the routed source, then ramps back up. Advances once per sample strobe.
module audio_mode_mux
   import audio_mix_pkg::*;
#(
   parameter int DATA_W    = 24,
   parameter int N_SRC     = 4,
   parameter int N_CH      = 2,
   parameter int RAMP_LOG2 = 6,
   parameter int SEL_W     = $clog2(N_SRC + 1)
) (
   input  logic                                   mclk,
   input  logic                                   reset,
   input  logic                                   next_lrclk_fall,
   input  logic [SEL_W-1:0]                       i_sel,
   input  logic                                   i_mute,
   input  logic [N_SRC-1:0][N_CH-1:0][DATA_W-1:0] i_src,
   output logic [N_CH-1:0][DATA_W-1:0]            o_data,
   output logic [SEL_W-1:0]                       o_active_sel,
   output logic                                   o_busy,
   output logic [1:0]                             o_dbg_state
);

   localparam int                GAIN_W = gain_width(RAMP_LOG2);
   localparam logic [GAIN_W-1:0] G_FULL = GAIN_W'(gain_full(RAMP_LOG2));
   localparam logic [SEL_W-1:0]  SEL_MUTE = SEL_W'(N_SRC);

   mix_state_t                  r_state;
   logic [GAIN_W-1:0]           r_gain;
   logic [SEL_W-1:0]            r_active;
   logic [SEL_W-1:0]            r_target;
   logic [N_CH-1:0][DATA_W-1:0] r_data;

   mix_state_t                  w_state_nxt;
   logic [GAIN_W-1:0]           w_gain_nxt;
   logic [SEL_W-1:0]            w_active_nxt;
   logic [SEL_W-1:0]            w_target_nxt;
   logic                        w_req_mute;
   logic                        w_leave;
   logic                        w_land;
   logic [N_CH-1:0][DATA_W-1:0] w_src;
   logic [N_CH-1:0][DATA_W-1:0] w_scaled;

   always_ff @(posedge mclk) begin
      if (reset) begin
         r_state  <= MUTED;
         r_gain   <= '0;
         r_active <= '0;
         r_target <= '0;
         r_data   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_gain   <= w_gain_nxt;
         r_active <= w_active_nxt;
         r_target <= w_target_nxt;
         if (next_lrclk_fall)
            r_data <= w_scaled;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_gain_nxt   = r_gain;
      w_active_nxt = r_active;
      w_target_nxt = r_target;
      w_leave      = 1'b0;
      w_land       = 1'b0;
      w_req_mute   = req_is_mute(i_mute, 32'(i_sel), 32'(N_SRC));
      if (next_lrclk_fall) begin
         w_target_nxt = w_req_mute ? SEL_MUTE : i_sel;
         w_leave      = w_req_mute || (i_sel != r_active);
         case (r_state)
            RUN: begin
               if (w_leave) begin
                  w_gain_nxt  = G_FULL - GAIN_W'(1);
                  w_state_nxt = FADE_OUT;
               end
            end
            FADE_OUT: begin
               w_gain_nxt = r_gain - GAIN_W'(1);
               w_land     = (w_gain_nxt == '0);
            end
            FADE_IN: begin
               // Reversing mid-ramp continues downward from the current gain, so no step.
               if (w_leave) begin
                  w_gain_nxt  = r_gain - GAIN_W'(1);
                  w_state_nxt = FADE_OUT;
                  w_land      = (w_gain_nxt == '0);
               end else begin
                  w_gain_nxt = r_gain + GAIN_W'(1);
                  if (w_gain_nxt == G_FULL)
                     w_state_nxt = RUN;
               end
            end
            MUTED: begin
               if (!w_req_mute) begin
                  w_active_nxt = i_sel;
                  w_gain_nxt   = GAIN_W'(1);
                  w_state_nxt  = FADE_IN;
               end
            end
            default: w_state_nxt = MUTED;
         endcase
         // At silence the newest request decides where to go next.
         if (w_land) begin
            if (w_target_nxt == SEL_MUTE) begin
               w_state_nxt = MUTED;
            end else begin
               w_active_nxt = w_target_nxt;
               w_state_nxt  = FADE_IN;
            end
         end
      end
   end

   always_comb begin
      w_src = '0;
      for (int s = 0; s < N_SRC; s++) begin
         if (w_active_nxt == SEL_W'(s))
            w_src = i_src[s];
      end
   end

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      gain_scaler #(
         .DATA_W    (DATA_W),
         .RAMP_LOG2 (RAMP_LOG2)
      ) u_gain_scaler (
         .i_sample (w_src[ch]),
         .i_gain   (w_gain_nxt),
         .o_scaled (w_scaled[ch])
      );
   end

   assign o_data       = r_data;
   assign o_active_sel = r_active;
   assign o_busy       = (r_state != RUN);
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_audio_mode_mux.sv
// Directed bench for audio_mode_mux with G=4: driver tasks push expected
// {state, busy, active, ch1, ch0} words; a monitor checks each strobe/reset edge.
module tb_audio_mode_mux;

   localparam int DATA_W = 24;
   localparam int N_SRC  = 4;
   localparam int N_CH   = 2;
   localparam int RL2    = 2;
   localparam int SEL_W  = 3;
   localparam int EW     = 2 + 1 + SEL_W + 2 * DATA_W;

   localparam logic [1:0] RN = 2'd0;
   localparam logic [1:0] FO = 2'd1;
   localparam logic [1:0] FI = 2'd2;
   localparam logic [1:0] MU = 2'd3;

   logic                                   mclk;
   logic                                   reset;
   logic                                   next_lrclk_fall;
   logic [SEL_W-1:0]                       i_sel;
   logic                                   i_mute;
   logic [N_SRC-1:0][N_CH-1:0][DATA_W-1:0] i_src;
   logic [N_CH-1:0][DATA_W-1:0]            o_data;
   logic [SEL_W-1:0]                       o_active_sel;
   logic                                   o_busy;
   logic [1:0]                             o_dbg_state;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] m_exp;
   logic [EW-1:0] m_act;
   int            n_cmp  = 0;
   int            n_fail = 0;

   audio_mode_mux #(
      .DATA_W    (DATA_W),
      .N_SRC     (N_SRC),
      .N_CH      (N_CH),
      .RAMP_LOG2 (RL2)
   ) dut (
      .mclk            (mclk),
      .reset           (reset),
      .next_lrclk_fall (next_lrclk_fall),
      .i_sel           (i_sel),
      .i_mute          (i_mute),
      .i_src           (i_src),
      .o_data          (o_data),
      .o_active_sel    (o_active_sel),
      .o_busy          (o_busy),
      .o_dbg_state     (o_dbg_state)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // Monitor: every edge that samples a strobe or reset produces one output word.
   always @(posedge mclk) begin
      if (next_lrclk_fall || reset) begin
         #1;
         n_cmp++;
         m_act = {o_dbg_state, o_busy, o_active_sel, o_data[1], o_data[0]};
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL underflow: output %h with no expected word", m_act);
         end else begin
            m_exp = exp_q.pop_front();
            if (m_act !== m_exp) begin
               n_fail++;
               $display("FAIL out #%0d: got st=%0d busy=%0b act=%0d ch1=%h ch0=%h, want st=%0d busy=%0b act=%0d ch1=%h ch0=%h",
                        n_cmp, m_act[EW-1 -: 2], m_act[EW-3], m_act[2*DATA_W +: SEL_W],
                        m_act[DATA_W +: DATA_W], m_act[0 +: DATA_W],
                        m_exp[EW-1 -: 2], m_exp[EW-3], m_exp[2*DATA_W +: SEL_W],
                        m_exp[DATA_W +: DATA_W], m_exp[0 +: DATA_W]);
            end
         end
      end
   end

   function automatic logic [EW-1:0] pack_exp(input logic [1:0] st, input logic [SEL_W-1:0] act,
                                              input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d0);
      return {st, (st != RN), act, d1, d0};
   endfunction

   // One strobe with independent per-channel expectations, followed by idle cycles.
   task automatic stb_lr(input logic [SEL_W-1:0] sel, input logic mute,
                         input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                         input logic [SEL_W-1:0] act, input logic [1:0] st);
      @(negedge mclk);
      i_sel  = sel;
      i_mute = mute;
      exp_q.push_back(pack_exp(st, act, d1, d0));
      next_lrclk_fall = 1'b1;
      @(negedge mclk);
      next_lrclk_fall = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge mclk);
   endtask

   task automatic stb(input logic [SEL_W-1:0] sel, input logic mute, input logic [DATA_W-1:0] d,
                      input logic [SEL_W-1:0] act, input logic [1:0] st);
      stb_lr(sel, mute, d, d, act, st);
   endtask

   task automatic do_reset(input int n, input logic with_strobe);
      @(negedge mclk);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(pack_exp(MU, '0, '0, '0));
         reset           = 1'b1;
         next_lrclk_fall = with_strobe;
         @(negedge mclk);
      end
      reset           = 1'b0;
      next_lrclk_fall = 1'b0;
      @(negedge mclk);
   endtask

   task automatic set_src(input int s, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
      i_src[s][0] = l;
      i_src[s][1] = r;
   endtask

   initial begin
      reset           = 1'b0;
      next_lrclk_fall = 1'b0;
      i_sel           = '0;
      i_mute          = 1'b0;
      set_src(0, 24'h100000, 24'h100000);
      set_src(1, 24'h200000, 24'h200000);
      set_src(2, 24'h300000, 24'h300000);
      set_src(3, 24'h080000, 24'h080000);

      // Reset, then ramp in on source 0.
      do_reset(2, 1'b0);
      stb(0, 0, 24'h040000, 0, FI);
      stb(0, 0, 24'h080000, 0, FI);
      stb(0, 0, 24'h0C0000, 0, FI);
      stb(0, 0, 24'h100000, 0, RN);
      stb(0, 0, 24'h100000, 0, RN);

      // Full switch 0 -> 1.
      stb(1, 0, 24'h0C0000, 0, FO);
      stb(1, 0, 24'h080000, 0, FO);
      stb(1, 0, 24'h040000, 0, FO);
      stb(1, 0, 24'h000000, 1, FI);
      stb(1, 0, 24'h080000, 1, FI);
      stb(1, 0, 24'h100000, 1, FI);
      stb(1, 0, 24'h180000, 1, FI);
      stb(1, 0, 24'h200000, 1, RN);

      // Mute in RUN, hold muted, release.
      stb(1, 1, 24'h180000, 1, FO);
      stb(1, 1, 24'h100000, 1, FO);
      stb(1, 1, 24'h080000, 1, FO);
      stb(1, 1, 24'h000000, 1, MU);
      stb(1, 1, 24'h000000, 1, MU);
      stb(1, 0, 24'h080000, 1, FI);
      stb(1, 0, 24'h100000, 1, FI);
      stb(1, 0, 24'h180000, 1, FI);
      stb(1, 0, 24'h200000, 1, RN);

      // Back to source 0, then reverse during FADE_IN at g=2 without a step.
      stb(0, 0, 24'h180000, 1, FO);
      stb(0, 0, 24'h100000, 1, FO);
      stb(0, 0, 24'h080000, 1, FO);
      stb(0, 0, 24'h000000, 0, FI);
      stb(0, 0, 24'h040000, 0, FI);
      stb(0, 0, 24'h080000, 0, FI);
      stb(1, 0, 24'h040000, 0, FO);
      stb(1, 0, 24'h000000, 1, FI);
      stb(1, 0, 24'h080000, 1, FI);
      stb(1, 0, 24'h100000, 1, FI);
      stb(1, 0, 24'h180000, 1, FI);
      stb(1, 0, 24'h200000, 1, RN);

      // Out-of-range select counts as mute; the newest target (2) wins at g=0.
      stb(3, 0, 24'h180000, 1, FO);
      stb(1, 0, 24'h100000, 1, FO);
      stb(4, 0, 24'h080000, 1, FO);
      stb(2, 0, 24'h000000, 2, FI);
      stb(2, 0, 24'h0C0000, 2, FI);
      stb(2, 0, 24'h180000, 2, FI);
      stb(2, 0, 24'h240000, 2, FI);
      stb(2, 0, 24'h300000, 2, RN);

      // Negative sample at g=1 and g=2 checks the arithmetic shift.
      do_reset(1, 1'b0);
      set_src(0, 24'hF00000, 24'h100000);
      stb_lr(0, 0, 24'hFC0000, 24'h040000, 0, FI);
      stb_lr(0, 0, 24'hF80000, 24'h080000, 0, FI);

      // Reset together with a strobe mid-FADE_OUT, then ramp in again from MUTED.
      set_src(0, 24'h100000, 24'h100000);
      stb(0, 0, 24'h0C0000, 0, FI);
      stb(0, 0, 24'h100000, 0, RN);
      stb(1, 0, 24'h0C0000, 0, FO);
      do_reset(1, 1'b1);
      stb(0, 0, 24'h040000, 0, FI);

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge mclk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: %0d expected words left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
